// File: rtl/inst_fetch_unit.sv
// Byte-serial instruction fetch with length decode for a small x86 opcode subset.
// Fetches one byte per memory handshake until the decoded length is reached, then holds it in DONE.
module inst_fetch_unit #(
  parameter int MAX_LEN = 6,
  parameter int ADDR_W  = 32
) (
  input  logic                   clock_4,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      eip,
  input  logic                   fetch_start,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_req,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [8*MAX_LEN-1:0]   inst_bytes,
  output logic [3:0]             num_of_ope,
  output logic                   illegal,
  output logic                   busy
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LEN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [8*MAX_LEN-1:0] buf_q, buf_d;
  logic [3:0]           len_q, len_d;
  logic                 ill_q, ill_d;
  logic [4:0]           dec_w;

  // Returns {illegal, length}. Before the ModRM byte arrives, ModRM opcodes report
  // a length of 2 so the fetch continues to byte1.
  function automatic logic [4:0] decode_len(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic have_b1);
    logic [4:0] r;
    logic       mod_reg;
    mod_reg = (b1[7:6] == 2'b11);
    case (b0) inside
      8'h90, [8'h40:8'h4F], 8'hC3, 8'hF4: r = {1'b0, 4'd1};
      8'hEB:                              r = {1'b0, 4'd2};
      [8'hB8:8'hBF], 8'h05, 8'hE9:        r = {1'b0, 4'd5};
      8'h89, 8'h8B:                       r = {have_b1 && !mod_reg, 4'd2};
      8'h83: begin
        if (!have_b1)     r = {1'b0, 4'd2};
        else if (mod_reg) r = {1'b0, 4'd3};
        else              r = {1'b1, 4'd2};
      end
      8'hC7: begin
        if (!have_b1)                          r = {1'b0, 4'd2};
        else if (mod_reg && b1[5:3] == 3'b000) r = {1'b0, 4'd6};
        else                                   r = {1'b1, 4'd2};
      end
      default:                            r = {1'b1, 4'd1};
    endcase
    return r;
  endfunction

  assign dec_w = decode_len(buf_q[7:0], buf_q[15:8], idx_q >= IDX_W'(2));

  always_ff @(posedge clock_4) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    len_d   = len_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          base_d  = eip;
          idx_d   = '0;
          buf_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (idx_q < IDX_W'(MAX_LEN)) buf_d[8*idx_q +: 8] = mem_rdata;
          idx_d   = idx_q + 1'b1;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (4'(idx_q) >= dec_w[3:0]) begin
          len_d   = dec_w[3:0];
          ill_d   = dec_w[4];
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        if (inst_ready) begin
          len_d   = '0;
          ill_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (state_q == S_REQ);
    mem_addr   = (state_q == S_REQ) ? base_q + ADDR_W'(idx_q) : '0;
    inst_valid = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    inst_bytes = buf_q;
    num_of_ope = len_q;
    illegal    = ill_q;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a byte memory responder of configurable wait states.
module tb_inst_fetch_unit;

  logic        clock_4 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] eip = '0;
  logic        fetch_start = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [47:0] inst_bytes;
  logic [3:0]  num_of_ope;
  logic        illegal;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] addr_log [16];
  int          n_acks = 0;
  int          wait_n = 0;
  int          unstable = 0;
  int          reset_at_ack = 0;

  inst_fetch_unit dut (
    .clock_4(clock_4), .reset(reset), .eip(eip), .fetch_start(fetch_start),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_bytes(inst_bytes),
    .num_of_ope(num_of_ope), .illegal(illegal), .busy(busy)
  );

  always #5 clock_4 = ~clock_4;

  // Memory acknowledges on the (wait_n+2)-th cycle a request is seen.
  initial begin
    int          req_cnt;
    logic [31:0] first_addr;
    req_cnt = 0;
    first_addr = '0;
    forever begin
      @(negedge clock_4);
      if (mem_req === 1'b1) begin
        if (req_cnt == 0) first_addr = mem_addr;
        else if (mem_addr !== first_addr) unstable++;
        req_cnt++;
        if (req_cnt == wait_n + 2) begin
          mem_ack = 1'b1;
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
          if (n_acks < 16) addr_log[n_acks] = mem_addr;
          n_acks++;
          req_cnt = 0;
          if (reset_at_ack != 0 && n_acks == reset_at_ack) reset = 1'b1;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        req_cnt = 0;
      end
    end
  end

  task automatic load(input logic [31:0] a, input int n, input logic [47:0] val);
    for (int i = 0; i < n; i++) mem[32'(a + 32'(i))] = val[8*i +: 8];
  endtask

  task automatic do_fetch(input logic [31:0] a, output int cyc);
    n_acks = 0;
    unstable = 0;
    @(negedge clock_4);
    eip = a;
    fetch_start = 1'b1;
    @(negedge clock_4);
    fetch_start = 1'b0;
    eip = 32'hDEAD_0000;
    cyc = 0;
    while (inst_valid !== 1'b1 && cyc < 200) begin
      @(negedge clock_4);
      cyc++;
    end
  endtask

  task automatic release_inst;
    @(negedge clock_4);
    inst_ready = 1'b1;
    @(negedge clock_4);
    inst_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock_4);
    reset = 1'b0;
    n_total++;
    if ({mem_req, mem_addr, inst_valid, inst_bytes, num_of_ope, illegal, busy} !== '0)
      $display("FAIL reset_outputs: req=%b addr=%h vld=%b bytes=%h len=%0d ill=%b busy=%b, expected all 0",
               mem_req, mem_addr, inst_valid, inst_bytes, num_of_ope, illegal, busy);
    else n_pass++;
  endtask

  task automatic test_one_byte;
    int cyc;
    load(32'h50, 1, 48'h90);
    do_fetch(32'h50, cyc);
    n_total++;
    if (cyc !== 3) $display("FAIL nop_latency: got %0d cycles, expected 3", cyc);
    else n_pass++;
    n_total++;
    if (addr_log[0] !== 32'h50 || n_acks !== 1)
      $display("FAIL nop_addr: addr=%h acks=%0d, expected 00000050 and 1", addr_log[0], n_acks);
    else n_pass++;
    n_total++;
    if (inst_bytes !== 48'h90 || num_of_ope !== 4'd1 || illegal !== 1'b0)
      $display("FAIL nop_result: bytes=%h len=%0d ill=%b, expected 000000000090 1 0",
               inst_bytes, num_of_ope, illegal);
    else n_pass++;
    release_inst();
  endtask

  task automatic test_mov_imm(input int w);
    int cyc;
    wait_n = w;
    load(32'h60, 5, 48'h0012345678B8);
    do_fetch(32'h60, cyc);
    n_total++;
    if (cyc !== 5 * (3 + w)) $display("FAIL mov_latency_w%0d: got %0d, expected %0d", w, cyc, 5 * (3 + w));
    else n_pass++;
    n_total++;
    if (n_acks !== 5 || addr_log[0] !== 32'h60 || addr_log[2] !== 32'h62 || addr_log[4] !== 32'h64 || unstable !== 0)
      $display("FAIL mov_addrs_w%0d: acks=%0d a0=%h a2=%h a4=%h unstable=%0d, expected 5 60 62 64 0",
               w, n_acks, addr_log[0], addr_log[2], addr_log[4], unstable);
    else n_pass++;
    n_total++;
    if (inst_bytes !== 48'h0012345678B8 || num_of_ope !== 4'd5 || illegal !== 1'b0)
      $display("FAIL mov_result_w%0d: bytes=%h len=%0d ill=%b, expected 0012345678b8 5 0",
               w, inst_bytes, num_of_ope, illegal);
    else n_pass++;
    release_inst();
    wait_n = 0;
  endtask

  task automatic test_modrm;
    int cyc;
    load(32'h100, 6, 48'hDEADBEEFC0C7);
    do_fetch(32'h100, cyc);
    n_total++;
    if (inst_bytes !== 48'hDEADBEEFC0C7 || num_of_ope !== 4'd6 || illegal !== 1'b0 || n_acks !== 6)
      $display("FAIL c7_result: bytes=%h len=%0d ill=%b acks=%0d, expected deadbeefc0c7 6 0 6",
               inst_bytes, num_of_ope, illegal, n_acks);
    else n_pass++;
    release_inst();
    load(32'h200, 3, 48'h770583);
    do_fetch(32'h200, cyc);
    n_total++;
    if (inst_bytes !== 48'h0583 || num_of_ope !== 4'd2 || illegal !== 1'b1 || n_acks !== 2)
      $display("FAIL 83_bad_modrm: bytes=%h len=%0d ill=%b acks=%0d, expected 000000000583 2 1 2",
               inst_bytes, num_of_ope, illegal, n_acks);
    else n_pass++;
    release_inst();
  endtask

  task automatic test_wrap_and_illegal;
    int cyc;
    load(32'hFFFF_FFFF, 1, 48'hE9);
    load(32'h0, 4, 48'h44332211);
    do_fetch(32'hFFFF_FFFF, cyc);
    n_total++;
    if (addr_log[0] !== 32'hFFFF_FFFF || addr_log[1] !== 32'h0)
      $display("FAIL wrap_addr: a0=%h a1=%h, expected ffffffff 00000000", addr_log[0], addr_log[1]);
    else n_pass++;
    n_total++;
    if (inst_bytes !== 48'h0044332211E9 || num_of_ope !== 4'd5 || illegal !== 1'b0)
      $display("FAIL wrap_result: bytes=%h len=%0d ill=%b, expected 0044332211e9 5 0",
               inst_bytes, num_of_ope, illegal);
    else n_pass++;
    release_inst();
    load(32'h300, 1, 48'h0F);
    do_fetch(32'h300, cyc);
    n_total++;
    if (inst_bytes !== 48'h0F || num_of_ope !== 4'd1 || illegal !== 1'b1)
      $display("FAIL bad_opcode: bytes=%h len=%0d ill=%b, expected 00000000000f 1 1",
               inst_bytes, num_of_ope, illegal);
    else n_pass++;
    release_inst();
  endtask

  task automatic test_hold;
    int cyc;
    int bad;
    bad = 0;
    load(32'h50, 1, 48'h90);
    do_fetch(32'h50, cyc);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin eip = 32'h60; fetch_start = 1'b1; end
      if (i == 4) fetch_start = 1'b0;
      @(negedge clock_4);
      if (inst_valid !== 1'b1 || inst_bytes !== 48'h90 || num_of_ope !== 4'd1 || mem_req !== 1'b0 || busy !== 1'b1)
        bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL hold_stable: %0d unstable cycles, expected 0", bad);
    else n_pass++;
    release_inst();
    n_total++;
    if (inst_valid !== 1'b0 || num_of_ope !== 4'd0)
      $display("FAIL hold_release: vld=%b len=%0d, expected 0 0", inst_valid, num_of_ope);
    else n_pass++;
    repeat (4) @(negedge clock_4);
    n_total++;
    if (busy !== 1'b0 || n_acks !== 1)
      $display("FAIL hold_drop: busy=%b acks=%0d, expected 0 1", busy, n_acks);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fetch;
    int cyc;
    int t;
    load(32'h60, 5, 48'h0012345678B8);
    reset_at_ack = 3;
    n_acks = 0;
    @(negedge clock_4);
    eip = 32'h60;
    fetch_start = 1'b1;
    @(negedge clock_4);
    fetch_start = 1'b0;
    t = 0;
    do begin
      @(posedge clock_4);
      t++;
    end while (reset !== 1'b1 && t < 200);
    #1;
    n_total++;
    if (t >= 200) $display("FAIL reset_mid_timeout: reset never reached after %0d cycles", t);
    else if ({mem_req, mem_addr, inst_valid, inst_bytes, num_of_ope, illegal, busy} !== '0)
      $display("FAIL reset_mid_outputs: req=%b addr=%h vld=%b bytes=%h len=%0d ill=%b busy=%b, expected all 0",
               mem_req, mem_addr, inst_valid, inst_bytes, num_of_ope, illegal, busy);
    else n_pass++;
    @(negedge clock_4);
    reset = 1'b0;
    reset_at_ack = 0;
    load(32'h50, 1, 48'h90);
    do_fetch(32'h50, cyc);
    n_total++;
    if (cyc !== 3 || inst_bytes !== 48'h90 || num_of_ope !== 4'd1 || illegal !== 1'b0)
      $display("FAIL post_reset_fetch: cyc=%0d bytes=%h len=%0d ill=%b, expected 3 000000000090 1 0",
               cyc, inst_bytes, num_of_ope, illegal);
    else n_pass++;
    release_inst();
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_mov_imm(0);
    test_mov_imm(2);
    test_modrm();
    test_wrap_and_illegal();
    test_hold();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
